// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Timing constants for 640x480 @ 60 Hz VGA raster generation, plus a small
// window-decode helper shared by the sync decoders.
//   VGA_*          : default porch/sync/display widths and the pixel divider
//   VGA_H/V_TOTAL  : full line / frame lengths
//   VGA_HS/VS_*    : first and last counter value of each sync pulse
//   VGA_COUNTER_W  : width of the Qh/Qv counters
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int VGA_CLK_DIV   = 4;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  localparam int VGA_COUNTER_W = 10;

  // True when lo <= value <= hi (unsigned, inclusive on both ends).
  function automatic logic in_window(input logic [VGA_COUNTER_W-1:0] value,
                                     input logic [VGA_COUNTER_W-1:0] lo,
                                     input logic [VGA_COUNTER_W-1:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/generador_tick.sv
// -----------------------------------------------------------------------------
// generador_tick
// Clock-enable divider: produces a one-cycle pixel enable every CLK_DIV cycles
// of the system clock. No derived clock is created.
//   reloj  : system clock
//   resetM : synchronous active-high reset
//   p_tick : registered enable, high in the cycle where the divider sits at
//            CLK_DIV-1 (first one CLK_DIV cycles after reset is released)
// CLK_DIV must be at least 2 so that p_tick is never high two cycles in a row.
// -----------------------------------------------------------------------------
module generador_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic reloj,
  input  logic resetM,
  output logic p_tick
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_tick;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
  end

  // The tick is decoded from the next divider value so that the registered
  // p_tick lines up with the cycle in which the divider shows CLK_DIV-1.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_tick <= (w_div_next == DIV_LAST);
    end
  end

  assign p_tick = r_tick;

endmodule

// File: rtl/sincronizador_vga.sv
// -----------------------------------------------------------------------------
// sincronizador_vga
// VGA raster timing generator: pixel enable, horizontal/vertical counters,
// active-low sync pulses, visible-area flag and a frame-wrap pulse.
//   reloj       : system clock
//   resetM      : synchronous active-high reset
//   p_tick      : pixel enable, one cycle in every CLK_DIV
//   Qh, Qv      : pixel / line counters (10 bits)
//   hsync       : horizontal sync, active low
//   vsync       : vertical sync, active low
//   video_on    : high while (Qh,Qv) is inside the visible area
//   frame_start : one-cycle pulse when the counters wrap from the last
//                 pixel of the frame to (0,0)
// The decodes are registered from the next-state counter values, so they
// change on the same edge as Qh/Qv and carry no extra latency.
// -----------------------------------------------------------------------------
module sincronizador_vga
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic                     reloj,
  input  logic                     resetM,
  output logic                     p_tick,
  output logic [VGA_COUNTER_W-1:0] Qh,
  output logic [VGA_COUNTER_W-1:0] Qv,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     video_on,
  output logic                     frame_start
);

  localparam int CW = VGA_COUNTER_W;

  localparam logic [CW-1:0] H_LAST   = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic          w_tick;
  logic [CW-1:0] r_qh, r_qv;
  logic [CW-1:0] w_qh_next, w_qv_next;
  logic          w_frame_wrap;
  logic          r_hsync, r_vsync, r_video_on, r_frame_start;

  generador_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_generador_tick (
    .reloj  (reloj),
    .resetM (resetM),
    .p_tick (w_tick)
  );

  // Next raster position. Qv only moves when Qh wraps.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_qh_next    = r_qh;
    w_qv_next    = r_qv;
    w_frame_wrap = 1'b0;
    if (w_tick) begin
      if (r_qh == H_LAST) begin
        w_qh_next = '0;
        if (r_qv == V_LAST) begin
          w_qv_next    = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_qv_next = r_qv + CW'(1);
        end
      end else begin
        w_qh_next = r_qh + CW'(1);
      end
    end
  end

  // Reset puts the raster at (0,0), which is visible and outside both sync
  // windows; any sync pulse in progress is cut off on the reset edge.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_qh          <= '0;
      r_qv          <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_qh          <= w_qh_next;
      r_qv          <= w_qv_next;
      r_hsync       <= ~in_window(w_qh_next, HS_START, HS_END);
      r_vsync       <= ~in_window(w_qv_next, VS_START, VS_END);
      r_video_on    <= (w_qh_next < H_VIS) && (w_qv_next < V_VIS);
      r_frame_start <= w_frame_wrap;
    end
  end

  assign p_tick      = w_tick;
  assign Qh          = r_qh;
  assign Qv          = r_qv;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sincronizador_vga.sv
// -----------------------------------------------------------------------------
// tb_sincronizador_vga
// Two instances share one clock:
//   dut_b : default 640x480 timing (reset release, line wrap, hsync window)
//   dut_s : shrunken timing, CLK_DIV=2, 15x13 raster (frame wrap, vsync
//           window, frame periods, mid-frame and random resets)
// The reference model derives every output from k, the number of clock edges
// since the last reset edge: ticks t = k / D, Qh = t mod HT,
// Qv = (t / HT) mod VT, p_tick = (k mod D == D-1).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sincronizador_vga;

  // Small-instance geometry
  localparam int S_D  = 2;
  localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VD = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;   // 15
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;   // 13

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s;
  logic       pt_b, hs_b, vs_b, vo_b, fs_b;
  logic [9:0] qh_b, qv_b;
  logic       pt_s, hs_s, vs_s, vo_s, fs_s;
  logic [9:0] qh_s, qv_s;

  sincronizador_vga dut_b (
    .reloj (clk), .resetM (rst_b), .p_tick (pt_b), .Qh (qh_b), .Qv (qv_b),
    .hsync (hs_b), .vsync (vs_b), .video_on (vo_b), .frame_start (fs_b)
  );

  sincronizador_vga #(
    .CLK_DIV (S_D),
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) dut_s (
    .reloj (clk), .resetM (rst_s), .p_tick (pt_s), .Qh (qh_s), .Qv (qv_s),
    .hsync (hs_s), .vsync (vs_s), .video_on (vo_s), .frame_start (fs_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  int k_b = 0, k_s = 0;
  bit valid_b = 0, valid_s = 0;

  always @(posedge clk) begin
    if (rst_b === 1'b1) begin k_b <= 0; valid_b <= 1; end else k_b <= k_b + 1;
    if (rst_s === 1'b1) begin k_s <= 0; valid_s <= 1; end else k_s <= k_s + 1;
  end

  task automatic model_check(input string tag, input int k, input int d,
                             input int hd, input int hf, input int hsw, input int ht,
                             input int vd, input int vf, input int vsw, input int vt,
                             input logic pt, input logic [9:0] qh, input logic [9:0] qv,
                             input logic hs, input logic vs, input logic vo, input logic fs);
    int t, mh, mv;
    t  = k / d;
    mh = t % ht;
    mv = (t / ht) % vt;
    check({tag, ".p_tick"},   32'(pt), 32'((k % d) == d - 1));
    check({tag, ".Qh"},       32'(qh), 32'(mh));
    check({tag, ".Qv"},       32'(qv), 32'(mv));
    check({tag, ".hsync"},    32'(hs), 32'(!(mh >= hd + hf && mh <= hd + hf + hsw - 1)));
    check({tag, ".vsync"},    32'(vs), 32'(!(mv >= vd + vf && mv <= vd + vf + vsw - 1)));
    check({tag, ".video_on"}, 32'(vo), 32'(mh < hd && mv < vd));
    check({tag, ".frame_start"}, 32'(fs), 32'(t > 0 && mh == 0 && mv == 0 && (k % d) == 0));
  endtask

  // Extremes of the counter values seen while a sync line is low.
  int hs_min_b = 1 << 20, hs_max_b = -1;
  int vs_min_s = 1 << 20, vs_max_s = -1;

  always @(negedge clk) begin
    if (valid_b) begin
      model_check("big", k_b, 4, 640, 16, 96, 800, 480, 10, 2, 525,
                  pt_b, qh_b, qv_b, hs_b, vs_b, vo_b, fs_b);
      if (hs_b == 1'b0) begin
        if (int'(qh_b) < hs_min_b) hs_min_b = int'(qh_b);
        if (int'(qh_b) > hs_max_b) hs_max_b = int'(qh_b);
      end
      if (pt_b && qh_b == 10'd639 && qv_b == 10'd10) check("big.video_on(639,10)", 32'(vo_b), 1);
      if (pt_b && qh_b == 10'd640 && qv_b == 10'd0)  check("big.video_on(640,0)",  32'(vo_b), 0);
    end
    if (valid_s) begin
      model_check("small", k_s, S_D, S_HD, S_HF, S_HS, S_HT, S_VD, S_VF, S_VS, S_VT,
                  pt_s, qh_s, qv_s, hs_s, vs_s, vo_s, fs_s);
      if (vs_s == 1'b0) begin
        if (int'(qv_s) < vs_min_s) vs_min_s = int'(qv_s);
        if (int'(qv_s) > vs_max_s) vs_max_s = int'(qv_s);
      end
      if (pt_s && qh_s == 10'd7 && qv_s == 10'd5) check("small.video_on(7,5)", 32'(vo_s), 1);
      if (pt_s && qh_s == 10'd0 && qv_s == 10'd6) check("small.video_on(0,6)", 32'(vo_s), 0);
    end
  end

  // ------------------------------------------------------- big instance
  task automatic run_big();
    int n;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("big.reset.Qh", 32'(qh_b), 0);
    check("big.reset.Qv", 32'(qv_b), 0);
    check("big.reset.p_tick", 32'(pt_b), 0);
    check("big.reset.hsync", 32'(hs_b), 1);
    check("big.reset.vsync", 32'(vs_b), 1);
    check("big.reset.video_on", 32'(vo_b), 1);
    check("big.reset.frame_start", 32'(fs_b), 0);
    rst_b = 1'b0;
    // Release cycle counts as cycle 1; p_tick appears in cycle 4.
    @(negedge clk); check("big.rel.c2.p_tick", 32'(pt_b), 0);
    @(negedge clk); check("big.rel.c3.p_tick", 32'(pt_b), 0);
    @(negedge clk); check("big.rel.c4.p_tick", 32'(pt_b), 1);
    check("big.rel.c4.Qh", 32'(qh_b), 0);
    @(negedge clk); check("big.rel.c5.Qh", 32'(qh_b), 1);
    check("big.rel.c5.Qv", 32'(qv_b), 0);

    n = 0;
    while (!(qh_b == 10'd799 && qv_b == 10'd10) && n < 40000) begin @(negedge clk); n++; end
    check("big.reach(799,10)", 32'(n < 40000), 1);
    n = 0;
    while (qh_b == 10'd799 && n < 10) begin @(negedge clk); n++; end
    check("big.linewrap.Qh", 32'(qh_b), 0);
    check("big.linewrap.Qv", 32'(qv_b), 11);
    check("big.hsync_first_low", 32'(hs_min_b), 656);
    check("big.hsync_last_low", 32'(hs_max_b), 751);
  endtask

  // ----------------------------------------------------- small instance
  task automatic wait_fs(output bit ok);
    int n = 0;
    while (fs_s !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ok = (n < 1000);
  endtask

  task automatic run_small();
    int n, cyc, hfall, vis;
    bit ok;
    logic prev_hs;
    rst_s = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b0;

    wait_fs(ok);
    check("small.first_frame_start", 32'(ok), 1);
    check("small.first_frame.Qh", 32'(qh_s), 0);
    check("small.first_frame.Qv", 32'(qv_s), 0);
    for (int f = 0; f < 2; f++) begin
      cyc = 0; hfall = 0; vis = 0; prev_hs = hs_s;
      do begin
        if (pt_s && vo_s) vis++;
        @(negedge clk);
        cyc++;
        if (prev_hs && !hs_s) hfall++;
        prev_hs = hs_s;
      end while (fs_s !== 1'b1 && cyc < 1000);
      check("small.frame_period", 32'(cyc), 32'(S_HT * S_VT * S_D));
      check("small.hsync_falls", 32'(hfall), 32'(S_VT));
      check("small.visible_ticks", 32'(vis), 32'(S_HD * S_VD));
    end
    check("small.vsync_first_low", 32'(vs_min_s), 32'(S_VD + S_VF));
    check("small.vsync_last_low", 32'(vs_max_s), 32'(S_VD + S_VF + S_VS - 1));

    // Frame wrap from the last position.
    n = 0;
    while (!(qh_s == 10'(S_HT - 1) && qv_s == 10'(S_VT - 1)) && n < 1000) begin @(negedge clk); n++; end
    check("small.reach_last", 32'(n < 1000), 1);
    n = 0;
    while (qh_s == 10'(S_HT - 1) && n < 10) begin @(negedge clk); n++; end
    check("small.wrap.Qh", 32'(qh_s), 0);
    check("small.wrap.Qv", 32'(qv_s), 0);
    check("small.wrap.frame_start", 32'(fs_s), 1);
    @(negedge clk);
    check("small.wrap.frame_start_once", 32'(fs_s), 0);

    // Mid-frame reset while hsync is low.
    n = 0;
    while (!(hs_s == 1'b0 && qv_s == 10'd7) && n < 1000) begin @(negedge clk); n++; end
    check("small.reach_hsync_low", 32'(n < 1000), 1);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    check("small.midrst.Qh", 32'(qh_s), 0);
    check("small.midrst.Qv", 32'(qv_s), 0);
    check("small.midrst.hsync", 32'(hs_s), 1);
    check("small.midrst.frame_start", 32'(fs_s), 0);

    // Random reset pulses; the per-cycle model tracks every restart.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_s = 1'b0;
    end
    repeat (500) @(negedge clk);
  endtask

  initial begin
    rst_b = 1'b1;
    rst_s = 1'b1;
    fork
      run_big();
      run_small();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sincronizador_vga.md
# sincronizador_vga

Generates the 640x480 @ 60 Hz VGA raster timing for the display path: a pixel-rate enable, the horizontal and vertical pixel counters `Qh`/`Qv`, the active-low sync pulses and a visible-area flag. It drives the pixel coordinates consumed by the character/mosaic renderer and the sync lines going to the monitor connector. All logic runs on one system clock. The pixel rate is obtained by a clock-enable divider, never by a derived clock.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz. Must be ≥ 2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BACK`, 48: horizontal back porch.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BACK`, 33: vertical back porch.

Ports:
- `reloj`, input, 1: system clock; all state changes on its rising edge.
- `resetM`, input, 1: synchronous, active-high reset.
- `p_tick`, output, 1: pixel enable; high for one `reloj` cycle in every `CLK_DIV` cycles.
- `Qh`, output, 10: horizontal pixel counter.
- `Qv`, output, 10: vertical line counter.
- `hsync`, output, 1: horizontal sync, active low.
- `vsync`, output, 1: vertical sync, active low.
- `video_on`, output, 1: high while (`Qh`,`Qv`) is inside the visible area.
- `frame_start`, output, 1: one-cycle pulse at each frame wrap.

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800.
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Divider: counter `div` runs 0..CLK_DIV-1 and wraps. `p_tick` is registered; it is high in the cycle where `div` == CLK_DIV-1.
- Counters advance only on cycles with `p_tick` = 1:
  - `Qh`: if `Qh` == H_TOTAL-1, `Qh` ← 0; otherwise `Qh` ← `Qh`+1.
  - `Qv` changes only when `Qh` wraps: if `Qv` == V_TOTAL-1, `Qv` ← 0; otherwise `Qv` ← `Qv`+1.
  - When `Qh` = 799 and `Qv` = 524, the next tick sets both to 0.
- Decodes:
  - `hsync` = 0 iff H_DISPLAY+H_FRONT ≤ `Qh` ≤ H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - `vsync` = 0 iff V_DISPLAY+V_FRONT ≤ `Qv` ≤ V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
  - `video_on` = (`Qh` < H_DISPLAY) && (`Qv` < V_DISPLAY).
- Decode outputs are registered. They are computed from the next-state counter values, so they are cycle-aligned with `Qh`/`Qv` (no skew).
- `frame_start`: high for exactly one `reloj` cycle, the cycle in which the counters first show (0,0) after a wrap from (799,524). It is not asserted on exit from reset.
- Counter widths: 10 bits unsigned. Comparisons are unsigned. Counters never reach H_TOTAL or V_TOTAL.

## Timing
- Reset values, applied on the first rising edge with `resetM` = 1:
  - `div` = 0, `p_tick` = 0, `Qh` = 0, `Qv` = 0.
  - `hsync` = 1, `vsync` = 1, `video_on` = 1, `frame_start` = 0.
- Reset asserted mid-line or mid-frame: all state returns to the reset values on that edge. No partial sync pulse continues.
- After `resetM` deasserts, the first `p_tick` occurs CLK_DIV cycles later.
- `Qh` increments on the edge following the cycle in which `p_tick` is high.
- Line period = 800 ticks = 3200 `reloj` cycles. Frame period = 525 lines = 1 680 000 `reloj` cycles.
- `hsync` low for 96 ticks (384 cycles) per line. `vsync` low for 2 lines (6400 cycles) per frame.
- Downstream blocks sample `Qh`/`Qv` with their own pipeline. This block adds no delay between the counters and the sync/`video_on` outputs.

## Structure
- Package `vga_timing_pkg`:
  - the eight timing constants;
  - H_TOTAL and V_TOTAL;
  - the sync start/end positions;
  - the counter width of 10.
- Sub-module `generador_tick`: the `CLK_DIV` divider producing `p_tick`, with ports `reloj`, `resetM`, `p_tick`.
- The top level holds the two counters and the registered decodes.

## Test plan
- Reset release: hold `resetM` high for 3 cycles, then release. Expect all reset values; first `p_tick` at cycle 4 after release; `Qh` = 1 one cycle later; `Qv` = 0.
- Line wrap: run to `Qh` = 799, `Qv` = 10. On the next tick expect `Qh` = 0, `Qv` = 11. Check `hsync` = 0 exactly for `Qh` 656..751.
- Frame wrap: run to (799,524). On the next tick expect (0,0) and `frame_start` high for one cycle. Check `vsync` = 0 only for `Qv` 490..491.
- Visible area: check `video_on` = 1 at (639,479), 0 at (640,0), 0 at (0,480), 1 at (0,0).
- Mid-frame reset: pulse `resetM` at (700,300) while `hsync` = 0. Next cycle expect `Qh` = 0, `Qv` = 0, `hsync` = 1, `frame_start` = 0.
- Period check over 2 frames:
  - 1 680 000 cycles between `frame_start` pulses;
  - 525 `hsync` falling edges per frame;
  - 307 200 `p_tick` cycles with `video_on` = 1 per frame.
